// File: rtl/hdmi_timing_ctrl.sv
// Raster timing generator and pixel-stream gate for a 640x480-class HDMI/TMDS output.
// Optional macro HDMI_TIMING_PATTERN_EN replaces black underflow fill with an XY test pattern.
module hdmi_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        pixclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        DrawArea,
    output logic        hSync,
    output logic        vSync,
    output logic [9:0]  CounterX,
    output logic [9:0]  CounterY,
    output logic        frame_start,
    output logic        streaming,
    output logic [15:0] underflow_cnt
);

    // Both totals must fit the 10-bit counters (<= 1024).
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_line_end;
    logic        w_frame_end;
    logic        w_active;
    logic        w_hsync;
    logic        w_vsync;
    logic        w_consume;
    logic        w_underflow;
    logic [23:0] w_sub;

    assign w_line_end  = (CounterX == H_LAST);
    assign w_frame_end = w_line_end && (CounterY == V_LAST);
    assign w_active    = ({1'b0, CounterX} < H_ACT_END) && ({1'b0, CounterY} < V_ACT_END);
    assign w_hsync     = ({1'b0, CounterX} >= HS_BEGIN) && ({1'b0, CounterX} < HS_END);
    assign w_vsync     = ({1'b0, CounterY} >= VS_BEGIN) && ({1'b0, CounterY} < VS_END);
    assign pix_ready   = w_active && (r_state == ST_RUN);
    assign w_consume   = pix_ready && pix_valid;
    assign w_underflow = pix_ready && !pix_valid;

`ifdef HDMI_TIMING_PATTERN_EN
    assign w_sub = {CounterX[7:0], CounterY[7:0], 8'hFF};
`else
    assign w_sub = 24'h000000;
`endif

    // Raster counters free-run in every state.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            CounterX <= 10'd0;
            CounterY <= 10'd0;
        end else if (w_line_end) begin
            CounterX <= 10'd0;
            CounterY <= (CounterY == V_LAST) ? 10'd0 : CounterY + 10'd1;
        end else begin
            CounterX <= CounterX + 10'd1;
        end
    end

    // State register.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: RUN is only entered or left on a frame boundary.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_next_state = ST_ARMED;
                else        w_next_state = ST_IDLE;
            end
            ST_ARMED: begin
                if (!enable)         w_next_state = ST_IDLE;
                else if (w_frame_end) w_next_state = ST_RUN;
                else                  w_next_state = ST_ARMED;
            end
            ST_RUN: begin
                if (w_frame_end && !enable) w_next_state = ST_IDLE;
                else                        w_next_state = ST_RUN;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Video outputs, one cycle behind the counter value that produced them.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            {red, green, blue} <= 24'h000000;
            DrawArea           <= 1'b0;
            hSync              <= 1'b0;
            vSync              <= 1'b0;
            frame_start        <= 1'b0;
            streaming          <= 1'b0;
        end else begin
            if (w_consume)     {red, green, blue} <= pix_data;
            else if (w_active) {red, green, blue} <= w_sub;
            else               {red, green, blue} <= 24'h000000;
            DrawArea    <= w_active;
            hSync       <= w_hsync;
            vSync       <= w_vsync;
            frame_start <= (CounterX == 10'd0) && (CounterY == 10'd0);
            streaming   <= (r_state == ST_RUN);
        end
    end

    // Saturating count of active RUN cycles with no pixel available.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            underflow_cnt <= 16'd0;
        end else if (w_underflow && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end else begin
            underflow_cnt <= underflow_cnt;
        end
    end

endmodule
